// File: rtl/lcd_rx_checker.sv
// lcd_rx_checker: receive-side monitor for the HD/VD/DEN LCD video stream.
// Samples the stream on rising NCLK edges seen in the CLK domain. Recovers
// pixel coordinates, checks line and frame geometry and reports per-frame status.
// Optional build macro LCD_RX_CHKSUM_EN enables the per-frame {R,G,B} checksum;
// without it CHKSUM is tied to zero.
module lcd_rx_checker #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int H_TOTAL  = 1056,
    parameter int V_TOTAL  = 525
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        NCLK,
    input  logic        HD,
    input  logic        VD,
    input  logic        DEN,
    input  logic [7:0]  R,
    input  logic [7:0]  G,
    input  logic [7:0]  B,
    output logic        PIX_VALID,
    output logic [10:0] X,
    output logic [9:0]  Y,
    output logic [23:0] PIX_RGB,
    output logic        FRAME_DONE,
    output logic        FRAME_OK,
    output logic [3:0]  ERR_FLAGS,
    output logic [15:0] FRAME_CNT,
    output logic [23:0] CHKSUM
);

    typedef enum logic {SEARCH, LOCK} state_t;

    // Saturation limits and parameter values sized to the counters they meet.
    localparam logic [10:0] H_MAX   = 11'h7FF;
    localparam logic [9:0]  L_MAX   = 10'h3FF;
    localparam logic [10:0] H_ACT_W = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACT_W = 10'(V_ACTIVE);
    localparam logic [10:0] H_TOT_W = 11'(H_TOTAL);
    localparam logic [9:0]  V_TOT_W = 10'(V_TOTAL);

    state_t      state, state_n;

    // Previous NCLK level and previous sampled sync/enable levels.
    logic        nclk_q, hd_q, vd_q, den_q;
    logic        pe, hd_fall, vd_fall, den_fall;

    // Per-frame tracking state.
    logic [10:0] x_cnt, x_n;
    logic [9:0]  y_cnt, y_n;
    logic [10:0] h_cnt, h_n;
    logic [9:0]  l_cnt, l_n;
    logic [3:0]  err, err_n;
    logic        hd_seen, hd_seen_n;

    // Next values of the registered outputs.
    logic        pix_valid_n, frame_done_n, frame_ok_n;
    logic [10:0] x_out_n;
    logic [9:0]  y_out_n;
    logic [23:0] rgb_out_n;
    logic [3:0]  flags_n;
    logic [15:0] fcnt_n;

`ifdef LCD_RX_CHKSUM_EN
    logic [23:0] acc, acc_n;
    logic [23:0] chk_q, chk_n;
`endif

    assign pe       = NCLK & ~nclk_q;
    assign hd_fall  = pe & hd_q  & ~HD;
    assign vd_fall  = pe & vd_q  & ~VD;
    assign den_fall = pe & den_q & ~DEN;

    // Next-state and datapath decode; one sample is processed per pe cycle,
    // in the order pixel, line close, HD fall, then frame check.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_n      = state;
        x_n          = x_cnt;
        y_n          = y_cnt;
        h_n          = h_cnt;
        l_n          = l_cnt;
        err_n        = err;
        hd_seen_n    = hd_seen;
        pix_valid_n  = 1'b0;
        frame_done_n = 1'b0;
        x_out_n      = X;
        y_out_n      = Y;
        rgb_out_n    = PIX_RGB;
        frame_ok_n   = FRAME_OK;
        flags_n      = ERR_FLAGS;
        fcnt_n       = FRAME_CNT;
`ifdef LCD_RX_CHKSUM_EN
        acc_n        = acc;
        chk_n        = chk_q;
`endif
        if (pe) begin
            case (state)
                SEARCH: begin
                    if (vd_fall) begin
                        state_n   = LOCK;
                        x_n       = '0;
                        y_n       = '0;
                        h_n       = '0;
                        l_n       = '0;
                        err_n     = '0;
                        hd_seen_n = 1'b0;
`ifdef LCD_RX_CHKSUM_EN
                        acc_n     = '0;
`endif
                    end
                end
                LOCK: begin
                    h_n = (h_cnt == H_MAX) ? H_MAX : h_cnt + 11'd1;
                    if (DEN) begin
                        pix_valid_n = 1'b1;
                        x_out_n     = x_cnt;
                        y_out_n     = y_cnt;
                        rgb_out_n   = {R, G, B};
                        x_n         = (x_cnt == H_MAX) ? H_MAX : x_cnt + 11'd1;
`ifdef LCD_RX_CHKSUM_EN
                        acc_n       = acc + {R, G, B};
`endif
                    end
                    if (den_fall) begin
                        if (x_cnt != H_ACT_W) err_n[0] = 1'b1;
                        y_n = (y_cnt == L_MAX) ? L_MAX : y_cnt + 10'd1;
                        x_n = '0;
                    end
                    if (hd_fall) begin
                        // The first HD fall after lock has no reference edge.
                        if (hd_seen && ((h_cnt != H_TOT_W) || (h_cnt == H_MAX)))
                            err_n[1] = 1'b1;
                        h_n       = 11'd1;
                        l_n       = (l_cnt == L_MAX) ? L_MAX : l_cnt + 10'd1;
                        hd_seen_n = 1'b1;
                    end
                    if (vd_fall) begin
                        if (y_n != V_ACT_W) err_n[2] = 1'b1;
                        if ((l_n != V_TOT_W) || (l_n == L_MAX)) err_n[3] = 1'b1;
                        flags_n      = err_n;
                        frame_ok_n   = (err_n == 4'd0);
                        frame_done_n = 1'b1;
                        fcnt_n       = FRAME_CNT + 16'd1;
                        err_n        = '0;
                        y_n          = '0;
                        l_n          = '0;
`ifdef LCD_RX_CHKSUM_EN
                        chk_n        = acc_n;
                        acc_n        = '0;
`endif
                    end
                end
                default: state_n = SEARCH;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register updates from pre-edge values regardless of statement order.
        if (!RST_n) state <= SEARCH;
        else        state <= state_n;
    end

    // Sample history, per-frame counters and registered outputs.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            nclk_q     <= 1'b0;
            hd_q       <= 1'b0;
            vd_q       <= 1'b0;
            den_q      <= 1'b0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            h_cnt      <= '0;
            l_cnt      <= '0;
            err        <= '0;
            hd_seen    <= 1'b0;
            PIX_VALID  <= 1'b0;
            X          <= '0;
            Y          <= '0;
            PIX_RGB    <= '0;
            FRAME_DONE <= 1'b0;
            FRAME_OK   <= 1'b0;
            ERR_FLAGS  <= '0;
            FRAME_CNT  <= '0;
        end else begin
            nclk_q <= NCLK;
            if (pe) begin
                hd_q  <= HD;
                vd_q  <= VD;
                den_q <= DEN;
            end
            x_cnt      <= x_n;
            y_cnt      <= y_n;
            h_cnt      <= h_n;
            l_cnt      <= l_n;
            err        <= err_n;
            hd_seen    <= hd_seen_n;
            PIX_VALID  <= pix_valid_n;
            X          <= x_out_n;
            Y          <= y_out_n;
            PIX_RGB    <= rgb_out_n;
            FRAME_DONE <= frame_done_n;
            FRAME_OK   <= frame_ok_n;
            ERR_FLAGS  <= flags_n;
            FRAME_CNT  <= fcnt_n;
        end
    end

`ifdef LCD_RX_CHKSUM_EN
    // Checksum accumulator and its per-frame latched copy.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            acc   <= '0;
            chk_q <= '0;
        end else begin
            acc   <= acc_n;
            chk_q <= chk_n;
        end
    end

    assign CHKSUM = chk_q;
`else
    assign CHKSUM = '0;
`endif

endmodule

// File: tb/tb_lcd_rx_checker.sv
// tb_lcd_rx_checker: table-driven frame bench for lcd_rx_checker, using a
// reduced 8x5 active / 12x7 total geometry so whole frames stay short.
`timescale 1ns/1ps
module tb_lcd_rx_checker;

    localparam int HA = 8;
    localparam int VA = 5;
    localparam int HT = 12;
    localparam int VT = 7;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        NCLK = 1'b0;
    logic        HD = 1'b1;
    logic        VD = 1'b1;
    logic        DEN = 1'b0;
    logic [7:0]  R = '0, G = '0, B = '0;
    logic        PIX_VALID, FRAME_DONE, FRAME_OK;
    logic [10:0] X;
    logic [9:0]  Y;
    logic [23:0] PIX_RGB, CHKSUM;
    logic [3:0]  ERR_FLAGS;
    logic [15:0] FRAME_CNT;

    int checks   = 0;
    int failures = 0;
    int pv_cnt   = 0;
    int done_cnt = 0;

    lcd_rx_checker #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .NCLK(NCLK), .HD(HD), .VD(VD), .DEN(DEN),
        .R(R), .G(G), .B(B),
        .PIX_VALID(PIX_VALID), .X(X), .Y(Y), .PIX_RGB(PIX_RGB),
        .FRAME_DONE(FRAME_DONE), .FRAME_OK(FRAME_OK), .ERR_FLAGS(ERR_FLAGS),
        .FRAME_CNT(FRAME_CNT), .CHKSUM(CHKSUM)
    );

    always #5 CLK = ~CLK;

    // Pulse counters; a pulse longer than one CLK is counted more than once.
    always @(negedge CLK) begin
        if (PIX_VALID)  pv_cnt++;
        if (FRAME_DONE) done_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pix_valid"},  32'(PIX_VALID),  0);
        check({tag, "_x"},          32'(X),          0);
        check({tag, "_y"},          32'(Y),          0);
        check({tag, "_rgb"},        32'(PIX_RGB),    0);
        check({tag, "_frame_done"}, 32'(FRAME_DONE), 0);
        check({tag, "_frame_ok"},   32'(FRAME_OK),   0);
        check({tag, "_err_flags"},  32'(ERR_FLAGS),  0);
        check({tag, "_frame_cnt"},  32'(FRAME_CNT),  0);
        check({tag, "_chksum"},     32'(CHKSUM),     0);
    endtask

    // One pixel period = 2 CLK; the DUT sees the NCLK rise at the second edge
    // and its registered response is sampled 1 ns after that edge.
    task automatic pix(input logic hd, input logic vd, input logic den,
                       input logic [23:0] rgb, output logic pv, output logic fd);
        @(posedge CLK); #1;
        NCLK = 1'b1; HD = hd; VD = vd; DEN = den;
        {R, G, B} = rgb;
        @(posedge CLK); #1;
        NCLK = 1'b0;
        pv = PIX_VALID;
        fd = FRAME_DONE;
    endtask

    task automatic idle(input int n);
        logic pv, fd;
        for (int i = 0; i < n; i++) pix(1'b1, 1'b1, 1'b0, 24'h0, pv, fd);
    endtask

    // Frame layout: HD low on pixels 0-1 of each line, VD low on lines 0-1
    // (both fall together at line 0 pixel 0), DEN on pixels 2.. of lines 1..n_act.
    task automatic play_frame(input int short_den, input int short_hp, input int n_act,
                              input int n_lines, input bit const_rgb, input int abort_line,
                              output logic fd_first, output int n_den);
        logic        pv, fd, hd, vd, den;
        logic [23:0] rgb;
        int          yy, period, width;
        bit          active;
        yy = 0;
        n_den = 0;
        fd_first = 1'b0;
        for (int l = 0; l < n_lines; l++) begin
            period = (l == short_hp)  ? HT - 1 : HT;
            width  = (l == short_den) ? HA - 1 : HA;
            active = (l >= 1) && (l <= n_act);
            for (int p = 0; p < period; p++) begin
                if (l == abort_line && p == 5) begin
                    RST_n = 1'b0;
                    #1;
                    check_zero("mid_reset");
                    repeat (3) @(posedge CLK);
                    #1;
                    check_zero("held_reset");
                    RST_n = 1'b1;
                    return;
                end
                hd  = (p < 2) ? 1'b0 : 1'b1;
                vd  = (l < 2) ? 1'b0 : 1'b1;
                den = active && (p >= 2) && (p < 2 + width);
                rgb = const_rgb ? 24'h000001 : {8'(p - 2), 8'(yy), 8'h5A};
                pix(hd, vd, den, rgb, pv, fd);
                if (l == 0 && p == 0) fd_first = fd;
                if (den) begin
                    n_den++;
                    check("pix_valid", 32'(pv), 1);
                    check("pix_x",     32'(X), 32'(p - 2));
                    check("pix_y",     32'(Y), 32'(yy));
                    check("pix_rgb",   32'(PIX_RGB), 32'(rgb));
                end
            end
            if (active) yy++;
        end
    endtask

    typedef struct {
        int         short_den;
        int         short_hp;
        int         n_act;
        int         n_lines;
        bit         const_rgb;
        bit         exp_done;   // report for the previous frame at this frame's start
        logic [3:0] exp_err;
        logic [15:0] exp_cnt;
        bit         chk_chk;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic        fd_first;
        int          n_den, pv0, done0;
        logic [23:0] exp_chk;

        vecs[0] = '{-1, -1, VA, VT, 1'b0, 1'b0, 4'b0000, 16'd0, 1'b0};
        vecs[1] = '{-1, -1, VA, VT, 1'b0, 1'b1, 4'b0000, 16'd1, 1'b0};
        vecs[2] = '{ 2, -1, VA, VT, 1'b0, 1'b1, 4'b0000, 16'd2, 1'b0};
        vecs[3] = '{-1, -1, VA, VT, 1'b0, 1'b1, 4'b0001, 16'd3, 1'b0};
        vecs[4] = '{-1,  3, VA, VT, 1'b0, 1'b1, 4'b0000, 16'd4, 1'b0};
        vecs[5] = '{-1, -1, VA-1, VT-1, 1'b0, 1'b1, 4'b0010, 16'd5, 1'b0};
        vecs[6] = '{-1, -1, VA, VT, 1'b0, 1'b1, 4'b1100, 16'd6, 1'b0};
        vecs[7] = '{-1, -1, VA, VT, 1'b1, 1'b1, 4'b0000, 16'd7, 1'b0};
        vecs[8] = '{-1, -1, VA, VT, 1'b0, 1'b1, 4'b0000, 16'd8, 1'b1};

`ifdef LCD_RX_CHKSUM_EN
        exp_chk = 24'(HA * VA);
`else
        exp_chk = 24'h0;
`endif

        repeat (3) @(posedge CLK);
        #1;
        check_zero("reset");
        RST_n = 1'b1;
        idle(3);

        for (int i = 0; i < 9; i++) begin
            pv0   = pv_cnt;
            done0 = done_cnt;
            play_frame(vecs[i].short_den, vecs[i].short_hp, vecs[i].n_act,
                       vecs[i].n_lines, vecs[i].const_rgb, -1, fd_first, n_den);
            check("frame_done_latency", 32'(fd_first), 32'(vecs[i].exp_done));
            check("frame_done_pulses", 32'(done_cnt - done0), 32'(vecs[i].exp_done));
            check("pix_valid_pulses", 32'(pv_cnt - pv0), 32'(n_den));
            check("frame_cnt", 32'(FRAME_CNT), 32'(vecs[i].exp_cnt));
            if (vecs[i].exp_done) begin
                check("err_flags", 32'(ERR_FLAGS), 32'(vecs[i].exp_err));
                check("frame_ok",  32'(FRAME_OK),  32'(vecs[i].exp_err == 4'd0));
            end
            if (vecs[i].chk_chk) check("chksum", 32'(CHKSUM), 32'(exp_chk));
        end

        // Reset in the middle of a line: the frame in progress is dropped.
        play_frame(-1, -1, VA, VT, 1'b0, 3, fd_first, n_den);
        check("abort_frame_done", 32'(fd_first), 1);
        idle(3);
        done0 = done_cnt;
        play_frame(-1, -1, VA, VT, 1'b0, -1, fd_first, n_den);
        check("relock_no_done", 32'(fd_first), 0);
        check("relock_no_pulse", 32'(done_cnt - done0), 0);
        check("relock_frame_cnt", 32'(FRAME_CNT), 0);
        play_frame(-1, -1, VA, VT, 1'b0, -1, fd_first, n_den);
        check("after_reset_done", 32'(fd_first), 1);
        check("after_reset_frame_cnt", 32'(FRAME_CNT), 1);
        check("after_reset_err", 32'(ERR_FLAGS), 0);
        check("after_reset_ok", 32'(FRAME_OK), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
